march_bist_ctrl: RTL
====================

MARCH_BIST_CTRL -- requirements
Module: march_bist_ctrl

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 7, giving the memory address width (2^ADDR_W words).
REQ-002 The module SHALL have parameter DATA_W, default 8, giving the memory word width.
REQ-003 The module SHALL have parameter STOP_ON_FAIL, default 0; when 1, the test aborts at the first mismatch.
REQ-004 The module SHALL have one clock and an asynchronous, active-high reset, ports as follows.
REQ-005 clk  in  1  clock; all state changes on the rising edge.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 start  in  1  test request, sampled only in IDLE.
REQ-008 busy  out  1  high while the test runs.
REQ-009 done  out  1  one-cycle completion pulse.
REQ-010 pass  out  1  result of the last completed test; 1 means no mismatch.
REQ-011 fail_count  out  8  mismatch count, saturating at 255.
REQ-012 first_fail_addr  out  ADDR_W  address of the first mismatch.
REQ-013 first_fail_elem  out  3  march element index (0-5) of the first mismatch.
REQ-014 first_fail_data  out  DATA_W  read data seen at the first mismatch.
REQ-015 mem_we  out  1  memory write enable; the memory write is synchronous.
REQ-016 mem_addr  out  ADDR_W  memory address.
REQ-017 mem_wdata  out  DATA_W  memory write data.
REQ-018 mem_rdata  in  DATA_W  memory read data, combinational from mem_addr in the same cycle.

Function
REQ-019 The controller SHALL have exactly three states: IDLE, RUN, DONE.
REQ-020 Transitions SHALL be: IDLE->RUN on start=1; RUN->DONE after the final operation or on an abort; DONE->IDLE unconditionally after one cycle.
REQ-021 The test SHALL be March C- using backgrounds Z=all-0 and O=all-1, one operation per cycle, in this element order:
- E0: any order (ascending), w Z.
- E1: ascending, r Z then w O.
- E2: ascending, r O then w Z.
- E3: descending, r Z then w O.
- E4: descending, r O then w Z.
- E5: ascending, r Z.
REQ-022 Ascending elements SHALL run addresses 0 to 2^ADDR_W-1; descending elements SHALL run 2^ADDR_W-1 to 0; both operations of a pair SHALL complete at one address before the address changes.
REQ-023 With the default parameters, RUN SHALL last exactly 1280 cycles (128 + 4x256 + 128).
REQ-024 If start is accepted at edge k, RUN SHALL occupy cycles k+1..k+1280 and done SHALL be high in cycle k+1281 only.
REQ-025 mem_we SHALL be 1 only during RUN write cycles; mem_wdata SHALL equal the write background in those cycles.
REQ-026 On every RUN read cycle, mem_rdata SHALL be compared with the expected background at that cycle's closing edge.
REQ-027 A mismatch SHALL increment fail_count (saturating at 255), SHALL clear pass, and, if it is the first mismatch of the run, SHALL capture first_fail_addr, first_fail_elem and first_fail_data.
REQ-028 On start acceptance, the controller SHALL set pass=1, fail_count=0, and all first_fail_* outputs to 0.
REQ-029 Result outputs SHALL hold their values from DONE until the next start acceptance.
REQ-030 start SHALL be ignored in RUN and DONE; start held high SHALL begin a new test on the first IDLE cycle.
REQ-031 With STOP_ON_FAIL=1, the cycle after the first mismatch SHALL be DONE; no further memory writes SHALL occur.
REQ-032 busy SHALL equal (state==RUN); done SHALL equal (state==DONE).
REQ-033 In IDLE and DONE, mem_addr and mem_wdata SHALL be 0.

Reset
REQ-034 While rst=1, the controller SHALL be in IDLE, regardless of clk and of any operation in progress.
REQ-035 While rst=1, busy, done, pass, mem_we, fail_count and all first_fail_* outputs SHALL all be 0.
REQ-036 A reset mid-RUN SHALL force mem_we low immediately, without waiting for a clock edge, and SHALL discard the partial results.
REQ-037 The first start after reset release SHALL run a complete test from E0, address 0.

Verification
REQ-038 Fault-free 128x8 memory model; start pulsed at edge k -> busy high k+1..k+1280, done high only in cycle k+1281, pass=1, fail_count=0.
REQ-039 Bit 0 stuck-at-1 at address 5, STOP_ON_FAIL=0 -> pass=0, fail_count=3 (reads in E1, E3, E5), first_fail_elem=1, first_fail_addr=5, first_fail_data=0x01.
REQ-040 Same fault, STOP_ON_FAIL=1, start at edge k -> mismatch in cycle k+139, done in cycle k+140, no mem_we at or after cycle k+140, fail_count=1.
REQ-041 Coupling fault (a write of 1 to address 10 flips address 9 to 0xFF) -> first_fail_elem=3, first_fail_addr=9, first_fail_data=0xFF.
REQ-042 rst asserted mid-cycle during RUN cycle 500 -> mem_we and busy drop before the next edge, all outputs 0; a subsequent start yields the full scenario REQ-038 result.
REQ-043 start held high continuously -> done pulses every 1282 cycles; start pulses during RUN have no effect; pass reflects each run independently.

Source files
------------

// File: rtl/march_bist_ctrl.sv
// March C- memory BIST controller: runs six march elements over a synchronous-write,
// combinational-read memory, one operation per cycle, and records the first mismatch.
module march_bist_ctrl #(
  parameter int ADDR_W       = 7,
  parameter int DATA_W       = 8,
  parameter int STOP_ON_FAIL = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [7:0]        fail_count,
  output logic [ADDR_W-1:0] first_fail_addr,
  output logic [2:0]        first_fail_elem,
  output logic [DATA_W-1:0] first_fail_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_MAX  = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic              STOP_EN   = (STOP_ON_FAIL != 32'sd0);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t              state_r, state_s;
  logic [2:0]          elem_r, next_elem_s;
  logic [ADDR_W-1:0]   addr_r, next_start_s;
  logic                phase_r;
  logic                is_write_s, pair_s, desc_s, addr_end_s, step_done_s;
  logic                elem_end_s, last_op_s, mismatch_s;
  logic [DATA_W-1:0]   exp_s;

  // Background of the current operation: 1 selects all-ones, 0 selects all-zeros.
  function automatic logic bg_is_one(input logic [2:0] elem, input logic is_write);
    logic one;
    one = 1'b0;
    case (elem)
      3'd1, 3'd3: one = is_write;
      3'd2, 3'd4: one = ~is_write;
      default:    one = 1'b0;
    endcase
    return one;
  endfunction

  // Decode the current march operation and its end-of-element conditions.
  always_comb begin
    is_write_s = 1'b0;
    pair_s     = 1'b0;
    desc_s     = 1'b0;
    case (elem_r)
      3'd0:       is_write_s = 1'b1;
      3'd1, 3'd2: begin pair_s = 1'b1; is_write_s = phase_r; end
      3'd3, 3'd4: begin pair_s = 1'b1; desc_s = 1'b1; is_write_s = phase_r; end
      default:    is_write_s = 1'b0;
    endcase
    exp_s        = bg_is_one(elem_r, is_write_s) ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
    addr_end_s   = desc_s ? (addr_r == ADDR_ZERO) : (addr_r == ADDR_MAX);
    step_done_s  = pair_s ? phase_r : 1'b1;
    elem_end_s   = step_done_s && addr_end_s;
    last_op_s    = (elem_r == 3'd5) && addr_end_s;
    mismatch_s   = (state_r == RUN) && !is_write_s && (mem_rdata != exp_s);
    next_elem_s  = elem_r + 3'd1;
    next_start_s = ((next_elem_s == 3'd3) || (next_elem_s == 3'd4)) ? ADDR_MAX : ADDR_ZERO;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_s;
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_s = RUN;
        else       state_s = IDLE;
      end
      RUN: begin
        if (last_op_s || (STOP_EN && mismatch_s)) state_s = DONE;
        else                                      state_s = RUN;
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Memory-side outputs; decoded from registered state so reset clears them at once.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = ADDR_ZERO;
    mem_wdata = {DATA_W{1'b0}};
    if (state_r == RUN) begin
      mem_we   = is_write_s;
      mem_addr = addr_r;
      if (is_write_s) mem_wdata = exp_s;
      else            mem_wdata = {DATA_W{1'b0}};
    end else begin
      mem_we = 1'b0;
    end
  end

  assign busy = (state_r == RUN);
  assign done = (state_r == DONE);

  // Element/address/phase sequencer; parked at E0, address 0 outside RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      elem_r  <= 3'd0;
      addr_r  <= ADDR_ZERO;
      phase_r <= 1'b0;
    end else if (state_r != RUN) begin
      elem_r  <= 3'd0;
      addr_r  <= ADDR_ZERO;
      phase_r <= 1'b0;
    end else if (!step_done_s) begin
      phase_r <= 1'b1;
    end else begin
      phase_r <= 1'b0;
      if (elem_end_s) begin
        elem_r <= next_elem_s;
        addr_r <= next_start_s;
      end else if (desc_s) begin
        addr_r <= addr_r - ADDR_ONE;
      end else begin
        addr_r <= addr_r + ADDR_ONE;
      end
    end
  end

  // Result registers; a zero count marks that no mismatch has been captured yet.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pass            <= 1'b0;
      fail_count      <= 8'd0;
      first_fail_addr <= ADDR_ZERO;
      first_fail_elem <= 3'd0;
      first_fail_data <= {DATA_W{1'b0}};
    end else if ((state_r == IDLE) && start) begin
      pass            <= 1'b1;
      fail_count      <= 8'd0;
      first_fail_addr <= ADDR_ZERO;
      first_fail_elem <= 3'd0;
      first_fail_data <= {DATA_W{1'b0}};
    end else if (mismatch_s) begin
      pass <= 1'b0;
      if (fail_count != 8'd255) fail_count <= fail_count + 8'd1;
      if (fail_count == 8'd0) begin
        first_fail_addr <= addr_r;
        first_fail_elem <= elem_r;
        first_fail_data <= mem_rdata;
      end
    end
  end

endmodule
